// File: rtl/imsic_setipnum_arbiter.sv
// Serialises per-interrupt-file setipnum writes onto one shared pending-bit update port.
// Each file owns a small FIFO; a round-robin arbiter feeds a single output register
// that speaks valid/ready to the pending-bit logic.
module imsic_setipnum_arbiter #(
    parameter int NR_SRC_LEN    = 32,
    parameter int NR_SRC        = 64,
    parameter int NR_INTP_FILES = 2,
    parameter int FIFO_DEPTH    = 4,
    localparam int FILE_W       = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1
) (
    input  logic                                  i_clk,
    input  logic                                  ni_rst,
    input  logic [NR_INTP_FILES*NR_SRC_LEN-1:0]   i_setipnum,
    input  logic [NR_INTP_FILES-1:0]              i_setipnum_we,
    output logic [NR_INTP_FILES-1:0]              o_drop,
    output logic [NR_INTP_FILES-1:0]              o_full,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic [FILE_W-1:0]                     o_file,
    output logic [NR_SRC_LEN-1:0]                 o_id,
    output logic                                  o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [NR_SRC_LEN-1:0] SRC_LIM   = NR_SRC_LEN'(NR_SRC);
    localparam logic [FILE_W-1:0]     LAST_FILE = FILE_W'(NR_INTP_FILES - 1);

    logic [NR_SRC_LEN-1:0]    mem_q  [NR_INTP_FILES][FIFO_DEPTH];
    logic [PW-1:0]            wptr_q [NR_INTP_FILES];
    logic [PW-1:0]            wptr_d [NR_INTP_FILES];
    logic [PW-1:0]            rptr_q [NR_INTP_FILES];
    logic [PW-1:0]            rptr_d [NR_INTP_FILES];
    logic [NR_INTP_FILES-1:0] empty, full, pop_f, push_f;
    logic [NR_INTP_FILES-1:0] drop_q, drop_d;
    logic                     valid_q, valid_d;
    logic [FILE_W-1:0]        file_q, file_d;
    logic [NR_SRC_LEN-1:0]    id_q, id_d;
    logic [FILE_W-1:0]        rr_q, rr_d;
    logic [FILE_W-1:0]        grant;
    logic [NR_SRC_LEN-1:0]    head;
    logic                     any_ne, load, pop;

    // FIFO occupancy flags from the extra-MSB pointer scheme
    always_comb begin
        empty = '0;
        full  = '0;
        for (int f = 0; f < NR_INTP_FILES; f++) begin
            empty[f] = (wptr_q[f] == rptr_q[f]);
            full[f]  = (wptr_q[f][PW-1] != rptr_q[f][PW-1]) &&
                       (wptr_q[f][AW-1:0] == rptr_q[f][AW-1:0]);
        end
    end

    assign any_ne = |(~empty);

    // Round-robin search: first non-empty FIFO at or after the RR pointer, wrapping
    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NR_INTP_FILES; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NR_INTP_FILES) idx = idx - NR_INTP_FILES;
            if (!found && !empty[idx]) begin
                grant = FILE_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign head = mem_q[grant][rptr_q[grant][AW-1:0]];

    // Output register loads whenever it is empty or being drained this cycle
    always_comb begin
        load    = !valid_q || i_ready;
        pop     = load && any_ne;
        valid_d = valid_q;
        file_d  = file_q;
        id_d    = id_q;
        rr_d    = rr_q;
        pop_f   = '0;
        for (int f = 0; f < NR_INTP_FILES; f++) begin
            pop_f[f] = pop && (grant == FILE_W'(f));
        end
        if (pop) begin
            valid_d = 1'b1;
            file_d  = grant;
            id_d    = head;
            rr_d    = (grant == LAST_FILE) ? '0 : grant + FILE_W'(1);
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Push acceptance: legal id and room, where a same-cycle pop frees a full FIFO
    always_comb begin
        logic [NR_SRC_LEN-1:0] id_f;
        id_f   = '0;
        push_f = '0;
        drop_d = '0;
        for (int f = 0; f < NR_INTP_FILES; f++) begin
            id_f      = i_setipnum[f*NR_SRC_LEN +: NR_SRC_LEN];
            push_f[f] = i_setipnum_we[f] && (id_f != '0) && (id_f < SRC_LIM) &&
                        (!full[f] || pop_f[f]);
            drop_d[f] = i_setipnum_we[f] && !push_f[f];
            wptr_d[f] = wptr_q[f] + PW'(push_f[f]);
            rptr_d[f] = rptr_q[f] + PW'(pop_f[f]);
        end
    end

    // Control state: pointers, output register, RR pointer and drop pulses
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            for (int f = 0; f < NR_INTP_FILES; f++) begin
                wptr_q[f] <= '0;
                rptr_q[f] <= '0;
            end
            valid_q <= 1'b0;
            file_q  <= '0;
            id_q    <= '0;
            rr_q    <= '0;
            drop_q  <= '0;
        end else begin
            for (int f = 0; f < NR_INTP_FILES; f++) begin
                wptr_q[f] <= wptr_d[f];
                rptr_q[f] <= rptr_d[f];
            end
            valid_q <= valid_d;
            file_q  <= file_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            drop_q  <= drop_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge i_clk) begin
        for (int f = 0; f < NR_INTP_FILES; f++) begin
            if (push_f[f]) begin
                mem_q[f][wptr_q[f][AW-1:0]] <= i_setipnum[f*NR_SRC_LEN +: NR_SRC_LEN];
            end
        end
    end

    assign o_valid = valid_q;
    assign o_file  = file_q;
    assign o_id    = id_q;
    assign o_drop  = drop_q;
    assign o_full  = full;
    assign o_busy  = valid_q | any_ne;

endmodule

// File: tb/tb_imsic_setipnum_arbiter.sv
// Scoreboard bench for imsic_setipnum_arbiter: directed writes push expected
// (file, id) pairs; a monitor pops and compares on every output transfer.
module tb_imsic_setipnum_arbiter;

    localparam int NL = 32;
    localparam int NS = 64;
    localparam int NF = 2;
    localparam int FD = 4;

    logic            clk = 1'b0;
    logic            ni_rst = 1'b0;
    logic [NF*NL-1:0] setipnum = '0;
    logic [NF-1:0]   we = '0;
    logic [NF-1:0]   drop, full;
    logic            valid;
    logic            ready = 1'b0;
    logic [0:0]      file;
    logic [NL-1:0]   id;
    logic            busy;

    typedef struct packed {
        logic [0:0]  f;
        logic [31:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic        stall_prev = 1'b0;
    logic [0:0]  hold_file;
    logic [31:0] hold_id;

    imsic_setipnum_arbiter #(
        .NR_SRC_LEN(NL), .NR_SRC(NS), .NR_INTP_FILES(NF), .FIFO_DEPTH(FD)
    ) dut (
        .i_clk(clk), .ni_rst(ni_rst), .i_setipnum(setipnum), .i_setipnum_we(we),
        .o_drop(drop), .o_full(full), .o_valid(valid), .i_ready(ready),
        .o_file(file), .o_id(id), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [0:0] f, input logic [31:0] v);
        exp_t e;
        e.f  = f;
        e.id = v;
        exp_q.push_back(e);
    endtask

    task automatic set_wr(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        we       = m;
        setipnum = {b, a};
    endtask

    // Monitor: inputs change just after posedge, so at negedge they are what the next edge sees
    always @(negedge clk) begin
        if (!ni_rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!(valid === 1'b1 && file === hold_file && id === hold_id)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b f=%0d id=%0h expected v=1 f=%0d id=%0h",
                             valid, file, id, hold_file, hold_id);
                end
            end
            if (valid === 1'b1 && ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_xfer: got f=%0d id=%0h expected no transfer", file, id);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (file !== e.f || id !== e.id) begin
                        errors++;
                        $display("FAIL xfer: got f=%0d id=%0h expected f=%0d id=%0h",
                                 file, id, e.f, e.id);
                    end
                end
            end
            stall_prev = (valid === 1'b1) && (ready === 1'b0);
            hold_file  = file;
            hold_id    = id;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_full",  32'(full),  0);
        chk("rst_drop",  32'(drop),  0);
        chk("rst_id",    id,         0);
        ni_rst = 1'b1;
        tick();

        // Single write: strobe cycle N -> valid in N+2
        ready = 1'b1;
        set_wr(2'b01, 5, 0); expect_out(0, 5);
        tick(); set_wr(2'b00, 0, 0);
        chk("t1_valid_n1", 32'(valid), 0);
        chk("t1_busy_n1",  32'(busy),  1);
        tick();
        chk("t1_valid_n2", 32'(valid), 1);
        chk("t1_id",       id,         5);
        chk("t1_file",     32'(file),  0);
        tick();
        chk("t1_valid_after", 32'(valid), 0);
        chk("t1_busy_after",  32'(busy),  0);

        // File1 write moves RR back to 0
        set_wr(2'b10, 0, 9); expect_out(1, 9);
        tick(); set_wr(2'b00, 0, 0);
        tick(); chk("t1b_file", 32'(file), 1);
        tick();

        // Same-cycle writes, RR=0: file0 then file1, RR ends at 0
        set_wr(2'b11, 3, 7); expect_out(0, 3); expect_out(1, 7);
        tick(); set_wr(2'b00, 0, 0);
        tick(); chk("t2_first_id",  id, 3);
        tick(); chk("t2_second_id", id, 7);
        tick(); chk("t2_idle", 32'(valid), 0);
        set_wr(2'b11, 10, 11); expect_out(0, 10); expect_out(1, 11);
        tick(); set_wr(2'b00, 0, 0);
        tick(); chk("t2_rr_file", 32'(file), 0);
        tick(); tick();

        // Stalled burst on file1: first id goes straight to the output register,
        // the next four fill the FIFO, the sixth is dropped
        ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            set_wr(2'b10, 0, k);
            if (k <= 5) expect_out(1, k);
            tick();
            chk("t3_drop", 32'(drop[1]), (k == 6) ? 1 : 0);
            if (k == 4) chk("t3_notfull", 32'(full[1]), 0);
            if (k >= 5) chk("t3_full", 32'(full[1]), 1);
        end
        set_wr(2'b00, 0, 0);
        tick();
        chk("t3_drop_pulse", 32'(drop[1]), 0);
        chk("t3_held_id",    id,           1);
        tick(); tick();
        ready = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        chk("t3_drained", 32'(busy), 0);

        // Illegal ids dropped; NR_SRC-1 is the largest legal id
        set_wr(2'b01, 0, 0);
        tick(); chk("t4_drop_id0", 32'(drop), 32'b01);
        set_wr(2'b01, NS, 0);
        tick(); chk("t4_drop_idmax", 32'(drop), 32'b01);
        set_wr(2'b00, 0, 0);
        tick();
        chk("t4_novalid", 32'(valid), 0);
        chk("t4_nobusy",  32'(busy),  0);
        set_wr(2'b01, NS - 1, 0); expect_out(0, NS - 1);
        tick(); chk("t4_nodrop_63", 32'(drop), 0);
        set_wr(2'b00, 0, 0);
        tick(); chk("t4_id63", id, NS - 1);
        tick();

        // Full FIFO accepts a write in the same cycle it is popped
        ready = 1'b0;
        for (int k = 11; k <= 15; k++) begin
            set_wr(2'b01, k, 0); expect_out(0, k);
            tick(); chk("t5_fill_drop", 32'(drop[0]), 0);
        end
        set_wr(2'b00, 0, 0);
        tick(); chk("t5_full", 32'(full[0]), 1);
        set_wr(2'b01, 16, 0); expect_out(0, 16); ready = 1'b1;
        tick();
        chk("t5_no_drop",   32'(drop[0]), 0);
        chk("t5_still_full", 32'(full[0]), 1);
        chk("t5_next_id",   id,           12);
        set_wr(2'b00, 0, 0);
        for (int k = 0; k < 7; k++) tick();
        chk("t5_drained", 32'(busy), 0);

        // Reset mid-transfer clears everything at once
        ready = 1'b0;
        set_wr(2'b11, 20, 22);
        tick(); set_wr(2'b01, 21, 0);
        tick(); set_wr(2'b00, 0, 0);
        tick();
        chk("t6_pre_valid", 32'(valid), 1);
        #2 ni_rst = 1'b0;
        #1;
        chk("t6_valid", 32'(valid), 0);
        chk("t6_busy",  32'(busy),  0);
        chk("t6_full",  32'(full),  0);
        chk("t6_id",    id,         0);
        chk("t6_file",  32'(file),  0);
        exp_q.delete();
        tick(); tick();
        ni_rst = 1'b1;
        ready  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_no_stale", 32'(valid), 0);
        end
        set_wr(2'b11, 40, 41); expect_out(0, 40); expect_out(1, 41);
        tick(); set_wr(2'b00, 0, 0);
        tick(); chk("t6_rr_reset_file", 32'(file), 0);
        tick(); chk("t6_second_file",   32'(file), 1);
        tick(); chk("t6_idle", 32'(valid), 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
